// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter slice:
// FSM state encoding, parity-type constants and default widths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PRESC_W    = 6;

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Word-input handshake of the UART transmitter: the producer offers
// P_DATA with in_valid, the transmitter accepts when in_ready is high.
interface uart_tx_cfg_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  in_valid;
    logic                  in_ready;

    modport master (
        output P_DATA,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  P_DATA,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-time prescaler: counts 0..presc-1 while a frame is running and
// flags the last cycle of each line bit. Restarts from 0 on frame load.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               restart,
    input  logic [PRESC_W-1:0] presc,     // already forced non-zero by the caller
    output logic               bit_tick
);

    logic [PRESC_W-1:0] cnt;

    assign bit_tick = en && (cnt == presc - PRESC_W'(1));

    // Prescale counter: held at 0 when idle, wraps at the end of each bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || restart || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: one-entry holding register on a
// valid/ready input, per-frame config snapshot, optional parity, 1/2 stop
// bits, and back-to-back frames with no idle gap.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PRESC_W    = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRESC_W-1:0] PRESCALE,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic               STOP2,
    uart_tx_cfg_if.slave       in_if,
    output logic               TX_OUT,
    output logic               busy,
    output logic               frame_done
);

    localparam int BCW = $clog2(DATA_WIDTH);

    uart_state_e           state;
    logic                  hr_valid;
    logic [DATA_WIDTH-1:0] hr_data;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bit;
    logic                  snap_par_en;
    logic                  snap_stop2;
    logic [PRESC_W-1:0]    snap_presc;
    logic [BCW-1:0]        bit_cnt;
    logic                  stop_cnt;

    logic                  bit_tick;
    logic                  last_stop;
    logic                  accept;
    logic                  load;

    assign in_if.in_ready = !hr_valid;
    assign accept         = in_if.in_valid && !hr_valid;
    assign busy           = (state != IDLE);
    assign last_stop      = !snap_stop2 || stop_cnt;
    // High during the last cycle of the final stop bit.
    assign frame_done     = (state == STOP) && bit_tick && last_stop;
    // Holding register moves into the shift register when idle or as the
    // current frame ends; accept never coincides since in_ready is then 0.
    assign load           = hr_valid && ((state == IDLE) || frame_done);

    uart_baud_gen #(
        .PRESC_W (PRESC_W)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .en       (busy),
        .restart  (load),
        .presc    (snap_presc),
        .bit_tick (bit_tick)
    );

    // Holding register, frame snapshot and transmit FSM with registered TX_OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            TX_OUT      <= 1'b1;
            hr_valid    <= 1'b0;
            hr_data     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            snap_par_en <= 1'b0;
            snap_stop2  <= 1'b0;
            snap_presc  <= PRESC_W'(1);
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch below sees the
            // pre-edge values of state, shreg and hr_valid.
            if (accept) begin
                hr_data  <= in_if.P_DATA;
                hr_valid <= 1'b1;
            end

            if (load) begin
                shreg       <= hr_data;
                hr_valid    <= 1'b0;
                snap_par_en <= PAR_EN;
                snap_stop2  <= STOP2;
                snap_presc  <= (PRESCALE == '0) ? PRESC_W'(1) : PRESCALE;
                case (PAR_TYP)
                    PAR_EVEN: par_bit <= ^hr_data;
                    PAR_ODD:  par_bit <= ~(^hr_data);
                endcase
                bit_cnt     <= '0;
                stop_cnt    <= 1'b0;
                state       <= START;
                TX_OUT      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        TX_OUT <= 1'b1;
                    end
                    START: begin
                        if (bit_tick) begin
                            state  <= DATA;
                            TX_OUT <= shreg[0];
                        end
                    end
                    DATA: begin
                        if (bit_tick) begin
                            if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
                                if (snap_par_en) begin
                                    state  <= PARITY;
                                    TX_OUT <= par_bit;
                                end else begin
                                    state  <= STOP;
                                    TX_OUT <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + BCW'(1);
                                shreg   <= shreg >> 1;
                                TX_OUT  <= shreg[1];
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_tick) begin
                            state  <= STOP;
                            TX_OUT <= 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_tick) begin
                            if (last_stop) begin
                                state  <= IDLE;
                                TX_OUT <= 1'b1;
                            end else begin
                                stop_cnt <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        TX_OUT <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised, runtime-configurable UART transmitter.
- Next generation of the UART TX path in the system's UART/register-file datapath.
- Additions over the previous TX:
  - generic data width
  - integrated baud prescaler
  - selectable 1/2 stop bits
  - valid/ready input handshake with a one-entry holding register, so back-to-back frames go out with zero idle gap
  - frame-done pulse

Parameters:
- DATA_WIDTH, 8, payload bits per frame; legal range 5..9.
- PRESC_W, 6, width of the PRESCALE input (clk cycles per bit).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- PRESCALE  in  PRESC_W  clk cycles per UART bit; value 0 treated as 1.
- PAR_EN  in  1  1 = parity bit inserted after data.
- PAR_TYP  in  1  0 = even, 1 = odd.
- STOP2  in  1  1 = two stop bits, 0 = one.
- P_DATA  in  DATA_WIDTH  parallel word to send.
- in_valid  in  1  P_DATA valid.
- in_ready  out  1  holding register empty; transfer occurs when in_valid && in_ready on a clk edge.
- TX_OUT  out  1  serial line, idle high.
- busy  out  1  high while a frame is on the line (START through the last STOP bit).
- frame_done  out  1  one-cycle pulse at the end of the last stop bit.

Behaviour:
- Reset values (async assert, sync-free deassert):
  - outputs: TX_OUT=1, busy=0, in_ready=1, frame_done=0
  - internals: FSM=IDLE, hold register empty, prescale and bit counters 0
- Holding register (HR):
  - in_ready = !hr_valid.
  - Accepted word is latched into HR.
  - HR is emptied when the FSM loads it into the shift register.
  - HR may be refilled during a frame.
- Config snapshot:
  - PRESCALE, PAR_EN, PAR_TYP and STOP2 are captured when HR is loaded into the shift register.
  - Changes mid-frame have no effect on that frame.
- Parity is computed at load time from the word: even = XOR of data bits; odd = inverted XOR.
- Bit timing:
  - Each line bit lasts exactly max(PRESCALE,1) clk cycles.
  - Prescale counter runs 0..P-1; bit_tick = (count==P-1).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TX_OUT=1. If hr_valid, load the shift register/snapshot and go to START on the next edge.
  - START: TX_OUT=0 for one bit time, then DATA.
  - DATA: TX_OUT = shift register LSB, LSB first. After DATA_WIDTH bit times, go to PARITY if PAR_EN, else STOP.
  - PARITY: TX_OUT = parity bit for one bit time, then STOP.
  - STOP: TX_OUT=1 for one bit time (two if STOP2). On the final bit_tick: frame_done=1 for that cycle; then go to START (loading HR) if hr_valid, else IDLE.
- Latency: word accepted at edge k → HR valid after k → TX_OUT falls at edge k+1 (if IDLE).
- Back-to-back: when HR is full at the end of STOP, the next START begins on the very next cycle, with no idle bit.
- Frame length = P*(1+DATA_WIDTH+PAR_EN+1+STOP2) cycles.
- busy is 1 in START/DATA/PARITY/STOP and 0 in IDLE. It stays 1 across back-to-back frames.
- Simultaneous events:
  - Accepting into HR and loading HR into the shift register in the same cycle is impossible, because in_ready=0 whenever HR is full.
  - Accepting while the FSM is mid-frame is allowed.
  - in_valid while in_ready=0 is ignored (the word is not consumed). The producer holds it.
- Reset mid-frame: TX_OUT returns to 1 immediately (async); HR is discarded and the frame is aborted.

Decomposition:
- Shared package uart_pkg:
  - state enum encoding (IDLE/START/DATA/PARITY/STOP)
  - parity type constants PAR_EVEN=0, PAR_ODD=1
  - default DATA_WIDTH/PRESC_W
- One natural sub-module: uart_baud_gen (prescale counter producing bit_tick, with restart on frame load).
- FSM, shift register, parity and HR stay in the top level.

Test Plan:
- Reset, DATA_WIDTH=8, PRESCALE=4, PAR_EN=0, STOP2=0; send 0xA5 → TX_OUT: 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. busy high for 40 cycles. frame_done pulses once. in_ready returns to 1 one cycle after accept.
- PAR_EN=1, PAR_TYP=0, data 0x07 → parity bit 1. PAR_TYP=1 → parity bit 0. Frame = 44 cycles at PRESCALE=4.
- Two words 0x55, 0x0F offered back-to-back, PRESCALE=1 → second START begins the cycle after the first STOP. busy never drops. in_ready=0 while HR is full.
- STOP2=1, PRESCALE=0 (treated as 1) → 11-cycle frame with two high stop cycles. Toggling STOP2/PAR_EN mid-frame leaves the frame unchanged.
- Assert rst during DATA bit 3 → TX_OUT=1, busy=0 and in_ready=1 immediately. After release, a new word 0x3C transmits correctly.
- DATA_WIDTH=5 build: send 0x13 with even parity → 5 data bits LSB first (1,1,0,0,1), parity 1, then stop.
